// File: rtl/rgb_pkg.sv
// Shared constants for the RGB light sequencer.
// Mode encodings, direction states and default widths.
package rgb_pkg;

  localparam logic [1:0] MODE_FWD      = 2'b00;
  localparam logic [1:0] MODE_REV      = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEF_NUM_COLORS = 3;
  localparam int DEF_DWELL_W    = 8;

endpackage

// File: rtl/rgb_dwell_timer.sv
// Dwell counter: ticks once every dwell+1 running cycles.
// Compare is >= so a shrinking dwell never lets cnt run away.
module rgb_dwell_timer
  import rgb_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  assign tick = run && (cnt_q >= dwell);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr:     cnt_d = '0;
      run:     cnt_d = tick ? '0 : cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_sequencer.sv
// One-hot colour sequencer with fwd/rev/ping-pong/hold modes.
// Index 0 maps to the light MSB; all outputs are registered.
module rgb_sequencer
  import rgb_pkg::*;
#(
  parameter  int NUM_COLORS = DEF_NUM_COLORS,
  parameter  int DWELL_W    = DEF_DWELL_W,
  localparam int IDX_W      =
    (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [NUM_COLORS-1:0] light,
  output logic [IDX_W-1:0]      idx,
  output logic                  step
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_COLORS - 1);
  localparam logic [NUM_COLORS-1:0] LIGHT_RST =
    NUM_COLORS'(1) << (NUM_COLORS - 1);

  logic                  hold;
  logic                  run;
  logic                  clr;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  dir_e                  dir_q;
  dir_e                  dir_d;
  logic [NUM_COLORS-1:0] light_q;
  logic [NUM_COLORS-1:0] light_d;
  logic                  step_q;

  assign hold = (mode == MODE_HOLD);
  assign run  = en && !hold;
  assign clr  = en && hold;

  rgb_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (clr),
    .dwell (dwell),
    .tick  (tick)
  );

  always_comb begin
    idx_d = idx_q;
    dir_d = dir_q;
    if (tick && (NUM_COLORS > 1)) begin
      unique case (1'b1)
        mode == MODE_FWD:
          idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        mode == MODE_REV:
          idx_d = (idx_q == '0) ? LAST : idx_q - 1'b1;
        mode == MODE_PINGPONG && dir_q == DIR_UP: begin
          if (idx_q == LAST) begin
            dir_d = DIR_DOWN;
            idx_d = idx_q - 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        mode == MODE_PINGPONG && dir_q == DIR_DOWN: begin
          if (idx_q == '0) begin
            dir_d = DIR_UP;
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    light_d = '0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      light_d[i] = (int'(idx_d) == NUM_COLORS - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      dir_q   <= DIR_UP;
      light_q <= LIGHT_RST;
      step_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      light_q <= light_d;
      step_q  <= tick;
    end
  end

  assign light = light_q;
  assign idx   = idx_q;
  assign step  = step_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Bench for rgb_sequencer: 3- and 4-colour instances on shared
// inputs, checked every cycle against a behavioural model.
module tb_rgb_sequencer;
  import rgb_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic [1:0] mode  = MODE_FWD;
  logic [7:0] dwell = '0;

  logic [2:0] light3;
  logic [1:0] idx3;
  logic       step3;
  logic [3:0] light4;
  logic [1:0] idx4;
  logic       step4;

  always #5 clk = ~clk;

  rgb_sequencer #(.NUM_COLORS(3), .DWELL_W(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .dwell (dwell),
    .light (light3),
    .idx   (idx3),
    .step  (step3)
  );

  rgb_sequencer #(.NUM_COLORS(4), .DWELL_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .dwell (dwell),
    .light (light4),
    .idx   (idx4),
    .step  (step4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference state: index 0 = 3-colour, 1 = 4-colour instance.
  int nc[2] = '{3, 4};
  int m_idx[2];
  int m_cnt[2];
  bit m_down[2];
  bit m_step[2];

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d]  = 0;
      m_cnt[d]  = 0;
      m_down[d] = 1'b0;
      m_step[d] = 1'b0;
    end
  endfunction

  function automatic void m_advance(int d);
    int n;
    n = nc[d];
    if (mode == MODE_FWD) begin
      m_idx[d] = (m_idx[d] + 1) % n;
    end else if (mode == MODE_REV) begin
      m_idx[d] = (m_idx[d] + n - 1) % n;
    end else if (n > 1) begin
      if (!m_down[d]) begin
        if (m_idx[d] == n - 1) begin
          m_down[d] = 1'b1;
          m_idx[d]--;
        end else begin
          m_idx[d]++;
        end
      end else begin
        if (m_idx[d] == 0) begin
          m_down[d] = 1'b0;
          m_idx[d]++;
        end else begin
          m_idx[d]--;
        end
      end
    end
  endfunction

  function automatic void m_tick();
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_step[d] = 1'b0;
      if (en && mode == MODE_HOLD) begin
        m_cnt[d] = 0;
      end else if (en) begin
        if (m_cnt[d] >= int'(dwell)) begin
          m_cnt[d]  = 0;
          m_step[d] = 1'b1;
          m_advance(d);
        end else begin
          m_cnt[d]++;
        end
      end
    end
  endfunction

  task automatic compare();
    chk("idx3",   idx3,   m_idx[0]);
    chk("light3", light3, 1 << (2 - m_idx[0]));
    chk("step3",  step3,  m_step[0]);
    chk("idx4",   idx4,   m_idx[1]);
    chk("light4", light4, 1 << (3 - m_idx[1]));
    chk("step4",  step4,  m_step[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_tick();
    #1;
    compare();
  endtask

  // Assert reset between edges and check outputs with no clock.
  task automatic areset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare();
    chk("ar_light3", light3, 3'b100);
    chk("ar_light4", light4, 4'b1000);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_step3(input string tag, input int lim);
    int k;
    k = 0;
    while (!step3 && k < lim) begin
      cyc();
      k++;
    end
    chk(tag, step3, 1'b1);
  endtask

  int k;
  int r;

  initial begin
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare();
    repeat (2) cyc();

    // Basic forward run, dwell 2.
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = MODE_FWD;
    dwell = 8'd2;
    repeat (12) cyc();

    // Reverse at dwell 0: new colour every cycle.
    mode  = MODE_REV;
    dwell = 8'd0;
    repeat (8) cyc();

    // Ping-pong from a clean start.
    areset();
    mode  = MODE_PINGPONG;
    dwell = 8'd0;
    repeat (10) cyc();

    // Pause mid-dwell at cnt=1, dwell=3.
    mode  = MODE_FWD;
    dwell = 8'd3;
    wait_step3("pause_sync", 10);
    cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    repeat (4) cyc();

    // Hold then forward: advance after dwell+1 cycles.
    mode = MODE_HOLD;
    repeat (3) cyc();
    mode = MODE_FWD;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!step3 && k < 10);
    chk("hold_exit", k, 4);

    // Dwell shrink mid-count.
    dwell = 8'd200;
    wait_step3("shrink_sync", 300);
    repeat (50) cyc();
    dwell = 8'd10;
    repeat (25) cyc();

    // Async reset while idx3 == 2.
    dwell = 8'd0;
    k = 0;
    while (idx3 != 2'd2 && k < 10) begin
      cyc();
      k++;
    end
    chk("ar_sync", idx3, 2'd2);
    areset();
    repeat (3) cyc();

    // Randomised run.
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 6) mode = 2'($urandom);
      if (r < 9) dwell = 8'($urandom_range(0, 4));
      en = ($urandom_range(0, 9) != 0);
      if (r == 99) areset();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
